// File: rtl/sort_reg_bank.sv
// sort_reg_bank: register bank with an in-place ascending bubble sorter.
// One compare-exchange per enabled cycle; a clean pass ends the sort early.
module sort_reg_bank #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  parameter  int SIGNED = 0,
  parameter  int CNT_W  = 8,
  localparam int ADDR_W = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] lim_q, lim_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] ip1;
  logic [WIDTH-1:0]  a, b;
  logic              gt;
  logic              wr_ok;

  assign ip1   = i_q + 1'b1;
  assign a     = mem_q[i_q];
  assign b     = mem_q[ip1];
  assign wr_ok = int'(wr_addr) < DEPTH;

  always_comb begin
    if (SIGNED != 0) gt = $signed(a) > $signed(b);
    else             gt = a > b;
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    i_d     = i_q;
    lim_d   = lim_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (wr && wr_ok) mem_d[wr_addr] = wr_data;
          if (start) begin
            state_d = SORT;
            i_d     = '0;
            lim_d   = ADDR_W'(DEPTH - 1);
            pass_d  = 1'b0;
            cnt_d   = '0;
          end
        end
        SORT: begin
          if (gt) begin
            mem_d[i_q] = b;
            mem_d[ip1] = a;
            pass_d     = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
          if (i_q == lim_q - 1'b1) begin
            // this edge's swap counts toward the pass
            if (!(pass_q || gt) || lim_q == ADDR_W'(1)) begin
              state_d = DONE;
            end else begin
              lim_d  = lim_q - 1'b1;
              i_d    = '0;
              pass_d = 1'b0;
            end
          end else begin
            i_d = ip1;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      state_q <= IDLE;
      i_q     <= '0;
      lim_q   <= ADDR_W'(DEPTH - 1);
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      i_q     <= i_d;
      lim_q   <= lim_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rd_data    = (int'(rd_addr) < DEPTH) ? mem_q[rd_addr] : '0;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign swap_count = cnt_q;

endmodule

// File: tb/tb_sort_reg_bank.sv
// Directed bench for sort_reg_bank: unsigned and signed instances
// share stimulus; vectors carry hand-computed results.
module tb_sort_reg_bank;

  typedef logic [0:7][7:0] row_t;

  typedef struct {
    string nm;
    row_t  din;
    row_t  eu;
    row_t  es;
    int    cu;
    int    cs;
    int    su;
    int    ss;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, en, wr, start;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_u, rd_s, cnt_u, cnt_s;
  logic       busy_u, done_u, busy_s, done_s;

  int total = 0;
  int bad   = 0;
  vec_t tbl [4];

  always #5 clk = ~clk;

  sort_reg_bank #(
    .WIDTH(8), .DEPTH(8), .SIGNED(0), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_u),
    .start(start), .busy(busy_u), .done(done_u),
    .swap_count(cnt_u)
  );

  sort_reg_bank #(
    .WIDTH(8), .DEPTH(8), .SIGNED(1), .CNT_W(8)
  ) s_dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_s),
    .start(start), .busy(busy_s), .done(done_s),
    .swap_count(cnt_s)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(row_t d);
    for (int k = 0; k < 8; k++) begin
      wr = 1'b1;
      wr_addr = 3'(k);
      wr_data = d[k];
      tick();
    end
    wr = 1'b0;
  endtask

  task automatic chk_mem(string nm, row_t eu, row_t es);
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1;
      chk($sformatf("%s u[%0d]", nm, k), 32'(rd_u), 32'(eu[k]));
      chk($sformatf("%s s[%0d]", nm, k), 32'(rd_s), 32'(es[k]));
    end
  endtask

  // Start, then poke a write and a start at cycle 3 (both must be ignored).
  task automatic run_sort(string nm, int ecu, int ecs, int esu, int ess);
    int n, du, ds;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr = 1'b0;
    chk({nm, " busy"}, 32'({busy_u, busy_s}), 32'b11);
    n = 0; du = -1; ds = -1;
    while ((du < 0 || ds < 0) && n < 200) begin
      if (n == 3) begin
        wr = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA; start = 1'b1;
      end else begin
        wr = 1'b0; start = 1'b0;
      end
      tick();
      n++;
      if (done_u && du < 0) du = n;
      if (done_s && ds < 0) ds = n;
    end
    wr = 1'b0; start = 1'b0;
    chk({nm, " cyc_u"}, 32'(du), 32'(ecu));
    chk({nm, " cyc_s"}, 32'(ds), 32'(ecs));
    tick();
    tick();
    chk({nm, " idle"}, 32'({busy_u, done_u, busy_s, done_s}), 32'b0);
    chk({nm, " swaps_u"}, 32'(cnt_u), 32'(esu));
    chk({nm, " swaps_s"}, 32'(cnt_s), 32'(ess));
  endtask

  initial begin
    int n;
    row_t desc, zero, z5;
    desc = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    zero = '0;
    z5   = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5};

    tbl[0] = '{nm: "asc",
      din: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
      eu:  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
      es:  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
      cu: 7, cs: 7, su: 0, ss: 0};
    tbl[1] = '{nm: "desc",
      din: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
      eu:  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
      es:  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
      cu: 28, cs: 28, su: 28, ss: 28};
    tbl[2] = '{nm: "mixed",
      din: {8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04},
      eu:  {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7F, 8'h80, 8'hFF},
      es:  {8'h80, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7F},
      cu: 22, cs: 18, su: 14, ss: 8};
    tbl[3] = '{nm: "equal",
      din: {8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5},
      eu:  {8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5},
      es:  {8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5},
      cu: 7, cs: 7, su: 0, ss: 0};

    rst = 1'b1; en = 1'b1; wr = 1'b0; start = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    #2;
    chk("rst flags", 32'({busy_u, done_u, busy_s, done_s}), 32'b0);
    chk("rst cnt", 32'({cnt_u, cnt_s}), 32'b0);
    chk_mem("rst", zero, zero);
    tick();
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      load(tbl[v].din);
      chk_mem({tbl[v].nm, " load"}, tbl[v].din, tbl[v].din);
      run_sort(tbl[v].nm, tbl[v].cu, tbl[v].cs, tbl[v].su, tbl[v].ss);
      chk_mem(tbl[v].nm, tbl[v].eu, tbl[v].es);
    end

    // start and write on the same edge over zeroed contents
    rst = 1'b1; tick(); rst = 1'b0;
    wr = 1'b1; wr_addr = 3'd7; wr_data = 8'h05;
    run_sort("st+wr", 7, 7, 0, 0);
    chk_mem("st+wr", z5, z5);

    // en low for 5 cycles after 10 enabled sort edges, then in DONE
    load(desc);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done_u && n < 200) begin
      if (n == 10) begin
        en = 1'b0;
        repeat (5) tick();
        chk("frz busy", 32'({busy_u, done_u}), 32'b10);
        chk("frz cnt", 32'(cnt_u), 32'd10);
        rd_addr = 3'd0; #1;
        chk("frz r0", 32'(rd_u), 32'd6);
        rd_addr = 3'd3; #1;
        chk("frz r3", 32'(rd_u), 32'd7);
        en = 1'b1;
      end
      tick();
      n++;
    end
    chk("frz cyc", 32'(n), 32'd28);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("done hold %0d", k), 32'({busy_u, done_u}), 32'b11);
    end
    en = 1'b1;
    tick();
    chk("done drop", 32'({busy_u, done_u}), 32'b0);
    chk("frz swaps", 32'(cnt_u), 32'd28);

    // reset in the middle of a sort
    load(desc);
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mid rst flags", 32'({busy_u, done_u, busy_s, done_s}), 32'b0);
    chk_mem("mid rst", zero, zero);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid rst done", 32'({done_u, done_s}), 32'b0);
    end
    rst = 1'b0;
    run_sort("post rst", 7, 7, 0, 0);
    chk_mem("post rst", zero, zero);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
